// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and jump-target table contents for the
// fetch sequencer.
package fetch_pkg;

    localparam int PC_W_DEF       = 10;
    localparam int START_ADDR_DEF = 0;
    localparam int CNT_W          = 16;
    localparam int LUT_IDX_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Absolute jump target for LUT slot idx; callers truncate to their PC width.
    function automatic int unsigned lut_entry(input logic [LUT_IDX_W-1:0] idx);
        return 32'(idx) << 5;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Control/status bundle between the decoder side (master) and the fetch
// sequencer (slave).
interface fetch_if #(
    parameter int PC_W = fetch_pkg::PC_W_DEF
);
    import fetch_pkg::*;

    logic                 Start;
    logic                 Halt;
    logic                 Jump;
    logic                 BranchEn;
    logic [LUT_IDX_W-1:0] JmpIdx;
    logic [PC_W-1:0]      ProgCtr;
    logic                 Running;
    logic                 Done;
    logic [CNT_W-1:0]     CycleCnt;

    modport master (
        output Start, Halt, Jump, BranchEn, JmpIdx,
        input  ProgCtr, Running, Done, CycleCnt
    );

    modport slave (
        input  Start, Halt, Jump, BranchEn, JmpIdx,
        output ProgCtr, Running, Done, CycleCnt
    );

endinterface

// File: rtl/jump_lut.sv
// Combinational jump-target table; kept apart so a program-specific table can
// replace it without touching the sequencer.
module jump_lut
    import fetch_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]      target
);

    always_comb begin
        target = PC_W'(lut_entry(idx));
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and IDLE/RUN/DONE fetch sequencer with LUT-resolved jumps
// and a saturating run-cycle counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = START_ADDR_DEF
) (
    input  logic  Clk,
    input  logic  Reset,
    fetch_if.slave bus
);

    localparam logic [1:0]      S_IDLE  = IDLE;
    localparam logic [1:0]      S_RUN   = RUN;
    localparam logic [1:0]      S_DONE  = DONE;
    localparam logic [PC_W-1:0] PC_INIT = PC_W'(START_ADDR);

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  jmp_tgt;

    jump_lut #(.PC_W(PC_W)) u_lut (
        .idx    (bus.JmpIdx),
        .target (jmp_tgt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                // The halting edge still counts as a RUN cycle.
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
                if (bus.Halt)
                    state_d = S_DONE;
                else if (bus.Jump && bus.BranchEn)
                    pc_d = jmp_tgt;
                else
                    pc_d = pc_q + PC_W'(1);
            end
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    state_d = S_RUN;
                    pc_d    = PC_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = PC_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ProgCtr  = pc_q;
    assign bus.CycleCnt = cnt_q;
    assign bus.Running  = (state_q == S_RUN);
    assign bus.Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a PC_W=10 instance and a PC_W=4 instance
// for wrap and LUT truncation.
module tb_fetch_unit;

    logic Clk = 1'b0;
    logic Reset;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 Clk = ~Clk;

    fetch_if #(.PC_W(10)) b10 ();
    fetch_if #(.PC_W(4))  b4 ();

    fetch_unit #(.PC_W(10), .START_ADDR(0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (b10)
    );

    fetch_unit #(.PC_W(4), .START_ADDR(0)) dut4 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (b4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge to sample/drive.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic ctl(input logic j, input logic be, input logic [4:0] idx, input logic h);
        b10.Jump = j; b10.BranchEn = be; b10.JmpIdx = idx; b10.Halt = h;
    endtask

    initial begin
        Reset = 1'b1;
        b10.Start = 0; ctl(0, 0, 5'd0, 0);
        b4.Start = 0; b4.Halt = 0; b4.Jump = 0; b4.BranchEn = 0; b4.JmpIdx = 5'd0;
        @(negedge Clk);
        step();

        // Reset state, then idle with no Start
        chk("rst_pc",   32'(b10.ProgCtr), 32'h0);
        chk("rst_run",  32'(b10.Running), 32'h0);
        chk("rst_done", 32'(b10.Done), 32'h0);
        chk("rst_cnt",  32'(b10.CycleCnt), 32'h0);
        Reset = 1'b0;
        repeat (5) step();
        chk("idle_pc",  32'(b10.ProgCtr), 32'h0);
        chk("idle_run", 32'(b10.Running), 32'h0);

        // Sequential fetch
        b10.Start = 1; step(); b10.Start = 0;
        chk("run_pc0", 32'(b10.ProgCtr), 32'h0);
        chk("run_on",  32'(b10.Running), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("seq_pc%0d", k), 32'(b10.ProgCtr), 32'(k));
        end
        chk("seq_cnt", 32'(b10.CycleCnt), 32'd5);

        // Start during RUN is ignored; reset mid-RUN at PC 9
        step();
        b10.Start = 1; step(); b10.Start = 0;
        chk("start_ign_pc",  32'(b10.ProgCtr), 32'd7);
        chk("start_ign_cnt", 32'(b10.CycleCnt), 32'd7);
        step(); step();
        chk("pre_rst_pc", 32'(b10.ProgCtr), 32'd9);
        Reset = 1; step(); Reset = 0;
        chk("midrst_pc",  32'(b10.ProgCtr), 32'h0);
        chk("midrst_run", 32'(b10.Running), 32'h0);
        chk("midrst_cnt", 32'(b10.CycleCnt), 32'h0);

        // Jumps: taken, not-taken, stray BranchEn, LUT[31], wrap at 0x3FF
        b10.Start = 1; step(); b10.Start = 0;
        repeat (3) step();
        chk("j_at3", 32'(b10.ProgCtr), 32'd3);
        ctl(1, 1, 5'd2, 0); step();
        chk("j_taken", 32'(b10.ProgCtr), 32'h040);
        ctl(1, 0, 5'd2, 0); step();
        chk("j_nottaken", 32'(b10.ProgCtr), 32'h041);
        ctl(0, 1, 5'd2, 0); step();
        chk("be_only", 32'(b10.ProgCtr), 32'h042);
        ctl(1, 1, 5'd31, 0); step();
        chk("lut31", 32'(b10.ProgCtr), 32'h3E0);
        ctl(0, 0, 5'd0, 0);
        repeat (31) step();
        chk("pc_max", 32'(b10.ProgCtr), 32'h3FF);
        step();
        chk("pc_wrap",  32'(b10.ProgCtr), 32'h0);
        chk("wrap_run", 32'(b10.Running), 32'h1);
        chk("j_cnt",    32'(b10.CycleCnt), 32'd39);

        // Halt beats a simultaneous taken jump; DONE holds; restart
        Reset = 1; step(); Reset = 0;
        b10.Start = 1; step(); b10.Start = 0;
        repeat (7) step();
        chk("h_at7", 32'(b10.ProgCtr), 32'd7);
        ctl(1, 1, 5'd2, 1); step();
        chk("halt_pc",   32'(b10.ProgCtr), 32'd7);
        chk("halt_done", 32'(b10.Done), 32'h1);
        chk("halt_run",  32'(b10.Running), 32'h0);
        chk("halt_cnt",  32'(b10.CycleCnt), 32'd8);
        ctl(1, 1, 5'd2, 0);
        step(); step();
        chk("done_pc",  32'(b10.ProgCtr), 32'd7);
        chk("done_cnt", 32'(b10.CycleCnt), 32'd8);
        ctl(0, 0, 5'd0, 0);
        b10.Start = 1; step(); b10.Start = 0;
        chk("restart_pc",   32'(b10.ProgCtr), 32'h0);
        chk("restart_cnt",  32'(b10.CycleCnt), 32'h0);
        chk("restart_run",  32'(b10.Running), 32'h1);
        chk("restart_done", 32'(b10.Done), 32'h0);

        // Reset wins over Start on the same edge
        Reset = 1; b10.Start = 1; step(); Reset = 0; b10.Start = 0;
        chk("rst_over_start", 32'(b10.Running), 32'h0);

        // PC_W=4: wrap from 15 to 0, LUT[31] truncates to 0
        b4.Start = 1; step(); b4.Start = 0;
        chk("w4_pc0", 32'(b4.ProgCtr), 32'h0);
        repeat (15) step();
        chk("w4_pc15", 32'(b4.ProgCtr), 32'hF);
        step();
        chk("w4_wrap", 32'(b4.ProgCtr), 32'h0);
        chk("w4_run",  32'(b4.Running), 32'h1);
        step();
        b4.Jump = 1; b4.BranchEn = 1; b4.JmpIdx = 5'd31; step();
        chk("w4_lut31", 32'(b4.ProgCtr), 32'h0);
        chk("w4_cnt",   32'(b4.CycleCnt), 32'd18);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
